// File: rtl/mem_stage_sram_ctrl_if.sv
// Bundle between the MEM-stage pipeline request, the SRAM controller and the external 16-bit SRAM.
// The slave modport is the controller; the master modport is the pipeline/SRAM side.
interface mem_stage_sram_ctrl_if;
  logic        memReadEn;
  logic        memWriteEn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  modport slave (
    input  memReadEn, memWriteEn, address, writeData, sram_dq_in,
    output readData, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output memReadEn, memWriteEn, address, writeData, sram_dq_in,
    input  readData, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Sequences one 32-bit pipeline load/store as two fixed-wait 16-bit SRAM phases (low, then high half).
// Access takes 2*WAIT_CYCLES+2 cycles; ready stays low (freezing the pipeline) until the DONE cycle.
module mem_stage_sram_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BASE   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_sram_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0] CNT_LAST  = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [31:0]   BASE_ADDR = 32'(ADDR_BASE);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rd_q, rd_d;

  logic        request;
  logic        is_write;
  logic        hi_half;
  logic        phase_last;
  logic [31:0] offs;
  logic        unused_addr_bits;

  assign request    = bus.memReadEn | bus.memWriteEn;
  // A simultaneous read+write is treated as a write.
  assign is_write   = bus.memWriteEn;
  assign hi_half    = (state_q == S_HIGH);
  assign phase_last = (cnt_q == CNT_LAST);
  assign offs       = bus.address - BASE_ADDR;

  assign unused_addr_bits = ^{offs[31:19], offs[1:0]};

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rd_d            = rd_q;
    bus.ready       = 1'b0;
    bus.sram_addr   = 18'd0;
    bus.sram_dq_out = 16'd0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;

    case (state_q)
      S_IDLE: begin
        bus.ready = ~request;
        if (request) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      end

      S_LOW, S_HIGH: begin
        bus.sram_addr = {offs[18:2], hi_half};
        if (is_write) begin
          bus.sram_dq_out = hi_half ? bus.writeData[31:16] : bus.writeData[15:0];
          bus.sram_dq_oe  = 1'b1;
          bus.sram_we_n   = 1'b0;
        end else if (phase_last) begin
          // Sample at the end of the phase so the async SRAM has had every wait state to settle.
          if (hi_half) rd_d[31:16] = bus.sram_dq_in;
          else         rd_d[15:0]  = bus.sram_dq_in;
        end

        if (phase_last) begin
          cnt_d   = '0;
          state_d = hi_half ? S_DONE : S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DONE: begin
        bus.ready = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.readData = rd_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench: per-cycle SRAM pin traces and completion read words are queued at issue time
// and popped by an independent negedge monitor.
module tb_mem_stage_sram_ctrl;

  localparam int W = 2;

  typedef struct packed {
    logic        rdy;
    logic [17:0] a;
    logic [15:0] d;
    logic        oe;
    logic        we_n;
  } pins_t;

  logic clk;
  logic rst;
  logic mem_clr;
  logic [15:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  pins_t       pin_q[$];
  logic [31:0] res_q[$];

  mem_stage_sram_ctrl_if sif ();

  mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM model: combinational read, write captured while we_n is low.
  assign sif.sram_dq_in = mem[sif.sram_addr[7:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1111;
    end else if (!rst && !sif.sram_we_n && sif.sram_dq_oe) begin
      mem[sif.sram_addr[7:0]] <= sif.sram_dq_out;
    end
  end

  function automatic pins_t mk(input logic rdy, input logic [17:0] a, input logic [15:0] d,
                               input logic oe, input logic we_n);
    pins_t p;
    p.rdy = rdy; p.a = a; p.d = d; p.oe = oe; p.we_n = we_n;
    return p;
  endfunction

  function automatic pins_t cur_pins();
    return mk(sif.ready, sif.sram_addr, sif.sram_dq_out, sif.sram_dq_oe, sif.sram_we_n);
  endfunction

  // Monitor: compare pins every cycle; on a request completing (ready high), compare readData.
  always @(negedge clk) begin
    pins_t got, exp;
    logic [31:0] exp_rd;
    if (!rst) begin
      got = cur_pins();
      if (sif.memReadEn || sif.memWriteEn) begin
        n_checks++;
        if (pin_q.size() == 0) begin
          n_errors++;
          $display("FAIL pin_underflow: got rdy=%0b addr=%0d with no expectation queued", got.rdy, got.a);
        end else begin
          exp = pin_q.pop_front();
          if (got !== exp) begin
            n_errors++;
            $display("FAIL pins t=%0t: got rdy=%0b addr=%0d dq=%h oe=%0b we_n=%0b, expected rdy=%0b addr=%0d dq=%h oe=%0b we_n=%0b",
                     $time, got.rdy, got.a, got.d, got.oe, got.we_n, exp.rdy, exp.a, exp.d, exp.oe, exp.we_n);
          end
        end
        if (sif.ready) begin
          n_checks++;
          if (res_q.size() == 0) begin
            n_errors++;
            $display("FAIL result_underflow: got readData=%h with no expectation queued", sif.readData);
          end else begin
            exp_rd = res_q.pop_front();
            if (sif.readData !== exp_rd) begin
              n_errors++;
              $display("FAIL readData t=%0t: got %h expected %h", $time, sif.readData, exp_rd);
            end
          end
        end
      end else begin
        n_checks++;
        if (got !== mk(1'b1, 18'd0, 16'd0, 1'b0, 1'b1)) begin
          n_errors++;
          $display("FAIL idle_pins t=%0t: got rdy=%0b addr=%0d dq=%h oe=%0b we_n=%0b, expected rdy=1 addr=0 dq=0000 oe=0 we_n=1",
                   $time, got.rdy, got.a, got.d, got.oe, got.we_n);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_trace(input bit wr, input logic [17:0] lo, input logic [15:0] dlo,
                            input logic [17:0] hi, input logic [15:0] dhi);
    pin_q.push_back(mk(1'b0, 18'd0, 16'd0, 1'b0, 1'b1));
    for (int i = 0; i < W; i++)
      pin_q.push_back(wr ? mk(1'b0, lo, dlo, 1'b1, 1'b0) : mk(1'b0, lo, 16'd0, 1'b0, 1'b1));
    for (int i = 0; i < W; i++)
      pin_q.push_back(wr ? mk(1'b0, hi, dhi, 1'b1, 1'b0) : mk(1'b0, hi, 16'd0, 1'b0, 1'b1));
    pin_q.push_back(mk(1'b1, 18'd0, 16'd0, 1'b0, 1'b1));
  endtask

  // Called just after a posedge; returns just after the posedge that ends DONE, request dropped.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [17:0] lo, input logic [15:0] dlo,
                        input logic [17:0] hi, input logic [15:0] dhi,
                        input logic [31:0] exp_rd);
    sif.memReadEn  = rd;
    sif.memWriteEn = wr;
    sif.address    = addr;
    sif.writeData  = wdata;
    push_trace(wr, lo, dlo, hi, dhi);
    res_q.push_back(exp_rd);
    repeat (2 * W + 2) @(posedge clk);
    #1;
    sif.memReadEn  = 1'b0;
    sif.memWriteEn = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    sif.memReadEn  = 1'b0;
    sif.memWriteEn = 1'b0;
    sif.address    = 32'd0;
    sif.writeData  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    rst = 1'b0;

    // Quiet period after reset: idle pins checked each cycle by the monitor.
    repeat (20) @(posedge clk);
    #1;
    check("reset_readData", sif.readData, 32'h0000_0000);

    // Write 0xDEADBEEF @1028 -> half addresses 2/3.
    access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 18'd2, 16'hBEEF, 18'd3, 16'hDEAD, 32'h0000_0000);
    check("sram_lo_after_write", {16'd0, mem[2]}, 32'h0000_BEEF);
    check("sram_hi_after_write", {16'd0, mem[3]}, 32'h0000_DEAD);

    // Read it back.
    access(1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 16'h0, 18'd3, 16'h0, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Back-to-back write then read of 1024 -> half addresses 0/1.
    access(1'b0, 1'b1, 32'd1024, 32'h1234_5678, 18'd0, 16'h5678, 18'd1, 16'h1234, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 16'h0, 18'd1, 16'h0, 32'h1234_5678);
    @(posedge clk); #1;

    // Read and write both high @1036 -> write to half addresses 6/7, readData unchanged.
    access(1'b1, 1'b1, 32'd1036, 32'hA5A5_A5A5, 18'd6, 16'hA5A5, 18'd7, 16'hA5A5, 32'h1234_5678);
    check("both_hi_readData_held", sif.readData, 32'h1234_5678);
    access(1'b1, 1'b0, 32'd1036, 32'h0, 18'd6, 16'h0, 18'd7, 16'h0, 32'hA5A5_A5A5);
    @(posedge clk); #1;

    // Reset during the HIGH phase of a write @1032 -> half addresses 4/5.
    sif.memWriteEn = 1'b1;
    sif.address    = 32'd1032;
    sif.writeData  = 32'h2222_3333;
    pin_q.push_back(mk(1'b0, 18'd0, 16'd0, 1'b0, 1'b1));
    for (int i = 0; i < W; i++) pin_q.push_back(mk(1'b0, 18'd4, 16'h3333, 1'b1, 1'b0));
    pin_q.push_back(mk(1'b0, 18'd5, 16'h2222, 1'b1, 1'b0));
    repeat (W + 1) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_we_n", {31'd0, sif.sram_we_n}, 32'd1);
    check("rst_oe", {31'd0, sif.sram_dq_oe}, 32'd0);
    check("rst_addr", {14'd0, sif.sram_addr}, 32'd0);
    @(posedge clk); #1;
    sif.memWriteEn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_ready", {31'd0, sif.ready}, 32'd1);
    check("post_rst_readData", sif.readData, 32'h0000_0000);
    check("rst_lo_written", {16'd0, mem[4]}, 32'h0000_3333);
    check("rst_hi_not_written", {16'd0, mem[5]}, 32'h0000_1111);

    repeat (3) @(posedge clk);
    #1;
    check("pin_q_drained", pin_q.size(), 32'd0);
    check("res_q_drained", res_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
